// File: rtl/pcie_rx.sv
// pcie_rx: TLP receive decoder for a 64-bit AXI stream from the PCIe core.
// Single-DW memory writes and reads become register strobes. Completions
// with data are re-packed into endian-swapped DW pairs. Every other TLP is
// discarded up to its rx_tlast.
module pcie_rx #(
    parameter int ADDR_BITS = 13
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [63:0]          rx_tdata,
    input  logic                 rx_tvalid,
    input  logic                 rx_tlast,
    output logic                 rx_tready,
    output logic                 wr_valid,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [31:0]          wr_data,
    output logic                 rd_valid,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic [31:0]          rd_dw2,
    output logic                 cpl_valid,
    output logic [7:0]           cpl_tag,
    output logic [63:0]          cpl_data,
    output logic                 cpl_last
);

    typedef enum logic [2:0] {HDR, H2, WDATA, CPL, DROP} state_t;
    typedef enum logic [1:0] {K_WR, K_RD, K_CPL, K_BAD} kind_t;

    function automatic logic [31:0] es(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    state_t                 state_q;
    kind_t                  kind_q, kind_d;
    logic                   is4_q;
    logic [9:0]             len_q, rem_q;
    logic [15:0]            req_id_q;
    logic [7:0]             tag_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            held_q;
    logic                   pend_q;

    logic                   wr_valid_q, rd_valid_q, cpl_valid_q, cpl_last_q;
    logic [ADDR_BITS-1:0]   wr_addr_q, rd_addr_q;
    logic [31:0]            wr_data_q, rd_dw2_q;
    logic [7:0]             cpl_tag_q;
    logic [63:0]            cpl_data_q;

    logic [31:0] lo, hi;
    logic        beat;

    assign lo        = rx_tdata[31:0];
    assign hi        = rx_tdata[63:32];
    assign rx_tready = ~reset;
    assign beat      = rx_tvalid & rx_tready;

    // Classify the header beat from fmt/type/length in DW0.
    always_comb begin
        kind_d = K_BAD;
        if (lo[28:24] == 5'h00 && lo[9:0] == 10'd1)
            kind_d = lo[30] ? K_WR : K_RD;
        else if (lo[30:29] == 2'b10 && lo[28:24] == 5'h0A)
            kind_d = K_CPL;
    end

    // Receive FSM with registered strobes and data outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= HDR;
            kind_q      <= K_BAD;
            is4_q       <= 1'b0;
            len_q       <= '0;
            rem_q       <= '0;
            req_id_q    <= '0;
            tag_q       <= '0;
            addr_q      <= '0;
            held_q      <= '0;
            pend_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            cpl_valid_q <= 1'b0;
            cpl_last_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            rd_dw2_q    <= '0;
            cpl_tag_q   <= '0;
            cpl_data_q  <= '0;
        end else begin
            wr_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            cpl_valid_q <= 1'b0;
            // An odd trailing DW that rode in with a pair-completing beat
            // goes out on the cycle after that pair.
            if (pend_q) begin
                pend_q      <= 1'b0;
                cpl_valid_q <= 1'b1;
                cpl_data_q  <= {32'd0, es(held_q)};
                cpl_last_q  <= 1'b1;
            end
            if (beat) begin
                case (state_q)
                    HDR: begin
                        kind_q   <= kind_d;
                        is4_q    <= lo[29];
                        len_q    <= lo[9:0];
                        req_id_q <= hi[31:16];
                        tag_q    <= hi[15:8];
                        if (rx_tlast)            state_q <= HDR;
                        else if (kind_d == K_BAD) state_q <= DROP;
                        else                     state_q <= H2;
                    end
                    H2: begin
                        case (kind_q)
                            K_WR: begin
                                if (is4_q) begin
                                    addr_q  <= hi[ADDR_BITS+1:2];
                                    state_q <= rx_tlast ? HDR : WDATA;
                                end else begin
                                    wr_valid_q <= 1'b1;
                                    wr_addr_q  <= lo[ADDR_BITS+1:2];
                                    wr_data_q  <= es(hi);
                                    state_q    <= rx_tlast ? HDR : DROP;
                                end
                            end
                            K_RD: begin
                                rd_valid_q <= 1'b1;
                                rd_addr_q  <= is4_q ? hi[ADDR_BITS+1:2] : lo[ADDR_BITS+1:2];
                                rd_dw2_q   <= {req_id_q, tag_q, 1'b0, is4_q ? hi[6:0] : lo[6:0]};
                                state_q    <= rx_tlast ? HDR : DROP;
                            end
                            K_CPL: begin
                                cpl_tag_q <= lo[15:8];
                                held_q    <= hi;
                                if (len_q == 10'd1) begin
                                    cpl_valid_q <= 1'b1;
                                    cpl_data_q  <= {32'd0, es(hi)};
                                    cpl_last_q  <= 1'b1;
                                    state_q     <= rx_tlast ? HDR : DROP;
                                end else begin
                                    // length 0 encodes 1024; wraps to 1023 here
                                    rem_q   <= len_q - 10'd1;
                                    state_q <= rx_tlast ? HDR : CPL;
                                end
                            end
                            default: state_q <= rx_tlast ? HDR : DROP;
                        endcase
                    end
                    WDATA: begin
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= addr_q;
                        wr_data_q  <= es(lo);
                        state_q    <= rx_tlast ? HDR : DROP;
                    end
                    CPL: begin
                        cpl_valid_q <= 1'b1;
                        cpl_data_q  <= {es(lo), es(held_q)};
                        if (rem_q == 10'd1) begin
                            cpl_last_q <= 1'b1;
                            state_q    <= rx_tlast ? HDR : DROP;
                        end else if (rem_q == 10'd2) begin
                            cpl_last_q <= 1'b0;
                            held_q     <= hi;
                            pend_q     <= 1'b1;
                            state_q    <= rx_tlast ? HDR : DROP;
                        end else begin
                            cpl_last_q <= 1'b0;
                            held_q     <= hi;
                            rem_q      <= rem_q - 10'd2;
                            state_q    <= rx_tlast ? HDR : CPL;
                        end
                    end
                    default: if (rx_tlast) state_q <= HDR;
                endcase
            end
        end
    end

    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_addr   = rd_addr_q;
    assign rd_dw2    = rd_dw2_q;
    assign cpl_valid = cpl_valid_q;
    assign cpl_tag   = cpl_tag_q;
    assign cpl_data  = cpl_data_q;
    assign cpl_last  = cpl_last_q;

endmodule
